// File: rtl/player_jump_fsm_if.sv
// -----------------------------------------------------------------------------
// player_jump_fsm_if
// Bundles the game-side control strobes and the player-height results that
// travel between the game logic and the jump engine.
//   tick        game-step strobe, one clk wide
//   jump_btn    raw jump button, asynchronous to clk
//   freeze      menu / victory / death screen active
//   distance    player height above ground (DW bits)
//   airborne    player is off the ground
//   landed      one-clk pulse when a fall reaches the ground
//   jump_count  jumps started, saturating at 255
// Modports: master = game logic side, slave = jump engine side.
// -----------------------------------------------------------------------------
interface player_jump_fsm_if #(
  parameter int DW = 10
);
  logic          tick;
  logic          jump_btn;
  logic          freeze;
  logic [DW-1:0] distance;
  logic          airborne;
  logic          landed;
  logic [7:0]    jump_count;

  modport master (
    output tick, jump_btn, freeze,
    input  distance, airborne, landed, jump_count
  );

  modport slave (
    input  tick, jump_btn, freeze,
    output distance, airborne, landed, jump_count
  );
endinterface

// File: rtl/player_jump_fsm.sv
// -----------------------------------------------------------------------------
// player_jump_fsm
// Tick-driven vertical-motion engine for the player sprite. The jump button is
// synchronised, edge-detected and latched as a jump request; each game tick
// then walks the height through a RISE / HOLD / FALL trajectory.
// freeze forces the player back to the ground on any clk.
//
// Ports:
//   clk       system clock (CLOCK_50)
//   reset_n   asynchronous active-low reset
//   bus       player_jump_fsm_if.slave: tick, jump_btn, freeze in;
//             distance, airborne, landed, jump_count out (all registered)
//
// Build option:
//   DOUBLE_JUMP_EN  when defined, one extra jump per airtime re-enters RISE
//                   from the current height. Undefined: airborne presses
//                   are ignored.
// -----------------------------------------------------------------------------
module player_jump_fsm #(
  parameter int DW         = 10,
  parameter int MAX_HEIGHT = 120,
  parameter int RISE_STEP  = 8,
  parameter int FALL_STEP  = 6,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  player_jump_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_HOLD = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [DW:0]   C_MAX  = (DW+1)'(MAX_HEIGHT);
  localparam logic [DW:0]   C_RISE = (DW+1)'(RISE_STEP);
  localparam logic [DW:0]   C_FALL = (DW+1)'(FALL_STEP);
  localparam logic [HW-1:0] C_HOLD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] C_ONE  = HW'(1);

  // Rising height clamps at the apex; one spare bit keeps the sum from wrapping.
  function automatic logic [DW-1:0] rise_sat(input logic [DW-1:0] d);
    logic [DW:0] s;
    s = {1'b0, d} + C_RISE;
    return (s >= C_MAX) ? C_MAX[DW-1:0] : s[DW-1:0];
  endfunction

  // Falling height clamps at ground instead of wrapping below zero.
  function automatic logic [DW-1:0] fall_sat(input logic [DW-1:0] d);
    return ({1'b0, d} <= C_FALL) ? '0 : (d - C_FALL[DW-1:0]);
  endfunction

  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : (c + 8'd1);
  endfunction

  state_t        r_state;
  logic [2:0]    r_sync;
  logic          r_jump_req;
  logic [HW-1:0] r_hold_cnt;
  logic [DW-1:0] r_distance;
  logic          r_airborne;
  logic          r_landed;
  logic [7:0]    r_jump_count;
`ifdef DOUBLE_JUMP_EN
  logic          r_dj_used;
  logic          w_dj_nxt;
`endif

  state_t        w_state_nxt;
  logic [DW-1:0] w_dist_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_start;
  logic          w_land;
  logic          w_edge;
  logic          w_req_nxt;
  logic          w_airborne_nxt;
  logic          w_landed_nxt;
  logic [7:0]    w_count_nxt;

  // r_sync[1:0] is the metastability pair; r_sync[2] is the edge-detect history.
  assign w_edge = r_sync[1] & ~r_sync[2];

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sync       <= '0;
      r_jump_req   <= 1'b0;
      r_hold_cnt   <= '0;
      r_distance   <= '0;
      r_airborne   <= 1'b0;
      r_landed     <= 1'b0;
      r_jump_count <= '0;
`ifdef DOUBLE_JUMP_EN
      r_dj_used    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sync       <= {r_sync[1:0], bus.jump_btn};
      r_jump_req   <= w_req_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_distance   <= w_dist_nxt;
      r_airborne   <= w_airborne_nxt;
      r_landed     <= w_landed_nxt;
      r_jump_count <= w_count_nxt;
`ifdef DOUBLE_JUMP_EN
      r_dj_used    <= w_dj_nxt;
`endif
    end
  end

  // Next-state logic: freeze beats tick; nothing moves between ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_dist_nxt  = r_distance;
    w_hold_nxt  = r_hold_cnt;
    w_start     = 1'b0;
    w_land      = 1'b0;
`ifdef DOUBLE_JUMP_EN
    w_dj_nxt    = r_dj_used;
`endif
    if (bus.freeze) begin
      w_state_nxt = S_IDLE;
      w_dist_nxt  = '0;
      w_hold_nxt  = '0;
`ifdef DOUBLE_JUMP_EN
      w_dj_nxt    = 1'b0;
`endif
    end else if (bus.tick) begin
`ifdef DOUBLE_JUMP_EN
      // Mid-air re-jump keeps the current height for this tick, like a ground start.
      if ((r_state != S_IDLE) && r_jump_req && !r_dj_used) begin
        w_state_nxt = S_RISE;
        w_start     = 1'b1;
        w_dj_nxt    = 1'b1;
      end else
`endif
      case (r_state)
        S_IDLE: begin
          if (r_jump_req) begin
            w_state_nxt = S_RISE;
            w_start     = 1'b1;
          end
        end
        S_RISE: begin
          w_dist_nxt = rise_sat(r_distance);
          if (w_dist_nxt == C_MAX[DW-1:0]) begin
            if (HOLD_TICKS == 0) begin
              w_state_nxt = S_FALL;
            end else begin
              w_state_nxt = S_HOLD;
              w_hold_nxt  = C_HOLD;
            end
          end
        end
        S_HOLD: begin
          w_hold_nxt = r_hold_cnt - C_ONE;
          if (r_hold_cnt == C_ONE) begin
            w_state_nxt = S_FALL;
          end
        end
        S_FALL: begin
          w_dist_nxt = fall_sat(r_distance);
          if (w_dist_nxt == '0) begin
            w_state_nxt = S_IDLE;
            w_land      = 1'b1;
`ifdef DOUBLE_JUMP_EN
            w_dj_nxt    = 1'b0;
`endif
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / request decode
  always_comb begin
    w_airborne_nxt = (w_state_nxt != S_IDLE);
    w_landed_nxt   = w_land;
    w_count_nxt    = w_start ? cnt_inc(r_jump_count) : r_jump_count;
    // Every tick consumes or drops the request; a fresh edge on that same clk survives.
    if (bus.freeze) begin
      w_req_nxt = 1'b0;
    end else begin
      w_req_nxt = w_edge | (r_jump_req & ~bus.tick);
    end
  end

  assign bus.distance   = r_distance;
  assign bus.airborne   = r_airborne;
  assign bus.landed     = r_landed;
  assign bus.jump_count = r_jump_count;

endmodule

// File: tb/tb_player_jump_fsm.sv
module tb_player_jump_fsm;
  localparam int DW   = 10;
  localparam int MAXH = 120;
  localparam int RS   = 8;
  localparam int FS   = 6;
  localparam int HT   = 4;
`ifdef DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  player_jump_fsm_if #(.DW(DW)) bus ();

  player_jump_fsm #(
    .DW(DW), .MAX_HEIGHT(MAXH), .RISE_STEP(RS), .FALL_STEP(FS), .HOLD_TICKS(HT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A flight is a precomputed list of heights, one per future tick.
  int m_h;
  int m_count;
  bit m_req;
  bit m_dj;
  bit m_landed;
  int m_q[$];
  bit m_b[3];

  task automatic plan_flight(input int from);
    int h;
    h = from;
    m_q.delete();
    do begin
      h = (h + RS > MAXH) ? MAXH : h + RS;
      m_q.push_back(h);
    end while (h < MAXH);
    for (int i = 0; i < HT; i++) m_q.push_back(MAXH);
    while (h > 0) begin
      h = (h > FS) ? h - FS : 0;
      m_q.push_back(h);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit e;
    if (!reset_n) begin
      m_h = 0; m_count = 0; m_req = 0; m_dj = 0; m_landed = 0;
      m_q.delete();
      m_b[0] = 0; m_b[1] = 0; m_b[2] = 0;
    end else begin
      // button sampled two clks ago vs three clks ago
      e = m_b[1] & ~m_b[2];
      m_b[2] = m_b[1]; m_b[1] = m_b[0]; m_b[0] = bus.jump_btn;
      m_landed = 0;
      if (bus.freeze) begin
        m_q.delete(); m_h = 0; m_req = 0; m_dj = 0;
      end else if (bus.tick) begin
        if (m_q.size() == 0) begin
          if (m_req) begin
            if (m_count < 255) m_count++;
            plan_flight(m_h);
          end
        end else if (DJ && m_req && !m_dj) begin
          m_dj = 1;
          if (m_count < 255) m_count++;
          plan_flight(m_h);
        end else begin
          m_h = m_q.pop_front();
          if (m_q.size() == 0) begin
            m_landed = 1; m_dj = 0;
          end
        end
        m_req = e;
      end else begin
        m_req = m_req | e;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      check("distance",   int'(bus.distance),   m_h);
      check("airborne",   int'(bus.airborne),   (m_q.size() != 0) ? 1 : 0);
      check("landed",     int'(bus.landed),     int'(m_landed));
      check("jump_count", int'(bus.jump_count), m_count);
    end
  end

  // ---------------- tick generator ----------------
  int tick_mode = 0;
  int tick_ph = 0;
  always @(negedge clk) begin
    #1;
    tick_ph++;
    case (tick_mode)
      1: bus.tick = 1'b1;
      2: bus.tick = tick_ph[0];
      3: bus.tick = ($urandom_range(0, 2) == 0);
      default: bus.tick = 1'b0;
    endcase
  end

  task automatic press_pulse();
    @(negedge clk); #1 bus.jump_btn = 1'b1;
    @(negedge clk); #1 bus.jump_btn = 1'b0;
  endtask

  task automatic wait_dist(input int val, input int lim, input string nm);
    int n;
    n = 0;
    while (n < lim && int'(bus.distance) != val) begin
      @(negedge clk); n++;
    end
    check(nm, int'(bus.distance), val);
  endtask

  task automatic wait_landed(input int lim, input string nm);
    int n;
    n = 0;
    while (n < lim && bus.landed !== 1'b1) begin
      @(negedge clk); n++;
    end
    check(nm, int'(bus.landed), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_distance", int'(bus.distance), 0);
    check("rst_airborne", int'(bus.airborne), 0);
    check("rst_landed",   int'(bus.landed),   0);
    check("rst_count",    int'(bus.jump_count), 0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int max_d, at_top, nonzero, lands, c0;
    bit seen_land;
    bus.jump_btn = 1'b0;
    bus.freeze   = 1'b0;
    do_reset();

    // idle ticks with no press
    tick_mode = 2;
    repeat (100) @(negedge clk);
    check("idle_distance", int'(bus.distance), 0);
    check("idle_airborne", int'(bus.airborne), 0);
    check("idle_count",    int'(bus.jump_count), 0);

    // single full jump, one tick per clk
    tick_mode = 1;
    press_pulse();
    max_d = 0; at_top = 0; nonzero = 0; lands = 0;
    repeat (80) begin
      @(negedge clk);
      if (int'(bus.distance) > max_d) max_d = int'(bus.distance);
      if (int'(bus.distance) == MAXH) at_top++;
      if (bus.distance != 0) nonzero++;
      if (bus.landed) lands++;
    end
    check("single_apex",      max_d, 120);
    check("single_top_ticks", at_top, 5);
    check("single_air_ticks", nonzero, 38);
    check("single_landed",    lands, 1);
    check("single_count",     int'(bus.jump_count), 1);
    check("model_count",      m_count, 1);

    // press while falling, then a second airborne press
    c0 = int'(bus.jump_count);
    press_pulse();
    wait_dist(120, 100, "dj_reach_apex");
    wait_dist(84, 100, "dj_reach_84");
    press_pulse();
    repeat (4) @(negedge clk);
    press_pulse();
    wait_landed(400, "dj_landed");
    check("dj_count_delta", int'(bus.jump_count) - c0, DJ ? 2 : 1);
    repeat (5) @(negedge clk);

    // freeze mid-rise
    c0 = int'(bus.jump_count);
    press_pulse();
    wait_dist(96, 100, "frz_reach_96");
    #1 bus.freeze = 1'b1;
    @(negedge clk);
    check("frz_distance", int'(bus.distance), 0);
    check("frz_airborne", int'(bus.airborne), 0);
    check("frz_landed",   int'(bus.landed), 0);
    seen_land = 1'b0;
    press_pulse();
    repeat (3) @(negedge clk);
    press_pulse();
    repeat (8) begin
      @(negedge clk);
      if (bus.landed) seen_land = 1'b1;
    end
    check("frz_no_land", int'(seen_land), 0);
    #1 bus.freeze = 1'b0;
    repeat (10) @(negedge clk);
    check("frz_after_air",   int'(bus.airborne), 0);
    check("frz_count_delta", int'(bus.jump_count) - c0, 1);

    // asynchronous reset during apex hold
    tick_mode = 2;
    press_pulse();
    wait_dist(120, 100, "ar_reach_apex");
    repeat (2) @(negedge clk);
    check("ar_airborne_before", int'(bus.airborne), 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_distance", int'(bus.distance), 0);
    check("ar_airborne", int'(bus.airborne), 0);
    check("ar_landed",   int'(bus.landed), 0);
    check("ar_count",    int'(bus.jump_count), 0);
    @(negedge clk); #1 reset_n = 1'b1;

    // randomized traffic
    tick_mode = 3;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 5) == 0) bus.jump_btn = ~bus.jump_btn;
      if (bus.freeze) begin
        if ($urandom_range(0, 3) == 0) bus.freeze = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        bus.freeze = 1'b1;
      end
    end
    #0 bus.freeze = 1'b0;
    bus.jump_btn = 1'b0;
    repeat (5) @(negedge clk);

    // counter saturation, 1-clk presses between ticks
    do_reset();
    tick_mode = 2;
    for (int j = 0; j < 256; j++) begin
      press_pulse();
      wait_landed(300, "sat_landed");
      @(negedge clk);
    end
    check("sat_count",       int'(bus.jump_count), 255);
    check("sat_model_count", m_count, 255);

    tick_mode = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
